// File: rtl/voting_session_ctrl.sv
// Voting booth session controller: edge-detected buttons drive a
// single-voter FSM that issues one vote strobe per confirmed selection.
module voting_session_ctrl #(
  parameter int CTR_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 admin_open,
  input  logic                 admin_close,
  input  logic                 voter_auth,
  input  logic [3:0]           cand_btn,
  input  logic                 confirm_btn,
  input  logic                 cancel_btn,
  output logic                 vote_en,
  output logic [1:0]           vote_sel,
  output logic [2:0]           state,
  output logic [CTR_WIDTH-1:0] votes_cast,
  output logic                 timeout_evt,
  output logic                 invalid_evt,
  output logic                 results_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CLOSED   = 3'd0,
    S_IDLE     = 3'd1,
    S_ARMED    = 3'd2,
    S_CONFIRM  = 3'd3,
    S_CAST     = 3'd4,
    S_COOLDOWN = 3'd5,
    S_FINAL    = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        cool_q, cool_d;
  logic [1:0]           sel_q, sel_d;
  logic [CTR_WIDTH-1:0] votes_q, votes_d;
  logic                 close_req_q, close_req_d;
  logic                 tmo_q, tmo_d;
  logic                 inv_q, inv_d;
  logic [8:0]           btn_q;

  logic [8:0] btn, btn_e;
  logic       open_e, close_e, auth_e, conf_e, canc_e;
  logic [3:0] cand_e;
  logic       cand_one;
  logic [1:0] cand_idx;

  assign btn = {admin_open, admin_close, voter_auth,
                cand_btn, confirm_btn, cancel_btn};
  assign btn_e = btn & ~btn_q;

  assign open_e  = btn_e[8];
  assign close_e = btn_e[7];
  assign auth_e  = btn_e[6];
  assign cand_e  = btn_e[5:2];
  assign conf_e  = btn_e[1];
  assign canc_e  = btn_e[0];

  assign cand_one = (cand_e != 4'd0) &&
                    ((cand_e & (cand_e - 4'd1)) == 4'd0);
  // Encoding is only meaningful when cand_one is set
  assign cand_idx = {cand_e[3] | cand_e[2],
                     cand_e[3] | cand_e[1]};

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cool_d      = cool_q;
    sel_d       = sel_q;
    votes_d     = votes_q;
    close_req_d = close_req_q;
    tmo_d       = 1'b0;
    inv_d       = 1'b0;
    case (state_q)
      S_CLOSED: begin
        if (open_e) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (close_e) begin
          state_d = S_FINAL;
        end else if (auth_e) begin
          state_d = S_ARMED;
          timer_d = TMR_LOAD;
        end
      end
      S_ARMED, S_CONFIRM: begin
        if (timer_q != '0) timer_d = timer_q - TW'(1);
        if (close_e) begin
          state_d = S_FINAL;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else if (canc_e) begin
          if (state_q == S_CONFIRM) begin
            state_d = S_ARMED;
            timer_d = TMR_LOAD;
          end
        end else if (conf_e) begin
          if (state_q == S_CONFIRM) state_d = S_CAST;
        end else if (cand_e != 4'd0) begin
          if (cand_one) begin
            sel_d   = cand_idx;
            state_d = S_CONFIRM;
            timer_d = TMR_LOAD;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      S_CAST: begin
        if (votes_q != '1) votes_d = votes_q + CTR_WIDTH'(1);
        cool_d      = CD_LOAD;
        state_d     = S_COOLDOWN;
        close_req_d = close_req_q | close_e;
      end
      S_COOLDOWN: begin
        close_req_d = close_req_q | close_e;
        if (cool_q == '0) begin
          state_d     = (close_req_q | close_e) ? S_FINAL : S_IDLE;
          close_req_d = 1'b0;
        end else begin
          cool_d = cool_q - CW'(1);
        end
      end
      S_FINAL: begin
        state_d = S_FINAL;
      end
      default: state_d = S_CLOSED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLOSED;
      timer_q     <= '0;
      cool_q      <= '0;
      sel_q       <= '0;
      votes_q     <= '0;
      close_req_q <= 1'b0;
      tmo_q       <= 1'b0;
      inv_q       <= 1'b0;
      btn_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cool_q      <= cool_d;
      sel_q       <= sel_d;
      votes_q     <= votes_d;
      close_req_q <= close_req_d;
      tmo_q       <= tmo_d;
      inv_q       <= inv_d;
      btn_q       <= btn;
    end
  end

  assign state         = state_q;
  assign vote_en       = (state_q == S_CAST);
  assign vote_sel      = sel_q;
  assign votes_cast    = votes_q;
  assign timeout_evt   = tmo_q;
  assign invalid_evt   = inv_q;
  assign results_valid = (state_q == S_FINAL);

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Bench for voting_session_ctrl: directed scenarios then random presses,
// per-cycle expectations and vote strobes checked via scoreboard queues.
module tb_voting_session_ctrl;

  localparam int T = 8;
  localparam int C = 4;

  localparam int M_CLOSED = 0;
  localparam int M_IDLE   = 1;
  localparam int M_ARMED  = 2;
  localparam int M_CONF   = 3;
  localparam int M_CAST   = 4;
  localparam int M_COOL   = 5;
  localparam int M_FINAL  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        admin_open = 0, admin_close = 0, voter_auth = 0;
  logic [3:0]  cand_btn = 0;
  logic        confirm_btn = 0, cancel_btn = 0;
  logic        vote_en;
  logic [1:0]  vote_sel;
  logic [2:0]  state;
  logic [15:0] votes_cast;
  logic        timeout_evt, invalid_evt, results_valid;

  always #5 clk = ~clk;

  voting_session_ctrl #(
    .CTR_WIDTH(16), .TIMEOUT_CYCLES(T), .COOLDOWN_CYCLES(C)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .admin_open(admin_open), .admin_close(admin_close),
    .voter_auth(voter_auth), .cand_btn(cand_btn),
    .confirm_btn(confirm_btn), .cancel_btn(cancel_btn),
    .vote_en(vote_en), .vote_sel(vote_sel), .state(state),
    .votes_cast(votes_cast), .timeout_evt(timeout_evt),
    .invalid_evt(invalid_evt), .results_valid(results_valid)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ven;
    logic [1:0]  sel;
    logic [15:0] votes;
    logic        tmo;
    logic        inv;
    logic        rv;
  } obs_t;

  obs_t expq[$];
  int   voteq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode, edges since last timer load, cooldown cycles
  int   m_mode, m_since, m_cool, m_sel, m_votes;
  bit   m_pend, m_tmo, m_inv;
  bit   p_open, p_close, p_auth, p_conf, p_canc;
  logic [3:0] p_cand;

  task automatic model_reset();
    m_mode = M_CLOSED; m_since = 0; m_cool = 0;
    m_sel = 0; m_votes = 0; m_pend = 0;
    m_tmo = 0; m_inv = 0;
    p_open = 0; p_close = 0; p_auth = 0;
    p_conf = 0; p_canc = 0; p_cand = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.st    = 3'(m_mode);
    o.ven   = (m_mode == M_CAST);
    o.sel   = 2'(m_sel);
    o.votes = 16'(m_votes);
    o.tmo   = m_tmo;
    o.inv   = m_inv;
    o.rv    = (m_mode == M_FINAL);
    return o;
  endfunction

  task automatic model_step(input bit o, input bit c, input bit a,
                            input logic [3:0] cd, input bit cf,
                            input bit cn);
    bit eo, ec, ea, ef, en;
    logic [3:0] ed;
    eo = o & !p_open;  ec = c & !p_close;
    ea = a & !p_auth;  ef = cf & !p_conf;
    en = cn & !p_canc; ed = cd & ~p_cand;
    m_tmo = 0; m_inv = 0;
    case (m_mode)
      M_CLOSED: if (eo) m_mode = M_IDLE;
      M_IDLE: begin
        if (ec) m_mode = M_FINAL;
        else if (ea) begin m_mode = M_ARMED; m_since = 0; end
      end
      M_ARMED, M_CONF: begin
        m_since++;
        if (ec) m_mode = M_FINAL;
        else if (m_since >= T) begin m_mode = M_IDLE; m_tmo = 1; end
        else if (en) begin
          if (m_mode == M_CONF) begin m_mode = M_ARMED; m_since = 0; end
        end else if (ef) begin
          if (m_mode == M_CONF) begin
            m_mode = M_CAST;
            voteq.push_back(m_sel);
          end
        end else if (ed != 0) begin
          if ($countones(ed) == 1) begin
            for (int i = 0; i < 4; i++) if (ed[i]) m_sel = i;
            m_mode = M_CONF; m_since = 0;
          end else m_inv = 1;
        end
      end
      M_CAST: begin
        if (ec) m_pend = 1;
        if (m_votes < 65535) m_votes++;
        m_mode = M_COOL; m_cool = 0;
      end
      M_COOL: begin
        if (ec) m_pend = 1;
        m_cool++;
        if (m_cool == C) begin
          m_mode = m_pend ? M_FINAL : M_IDLE;
          m_pend = 0;
        end
      end
      default: ;
    endcase
    p_open = o; p_close = c; p_auth = a;
    p_cand = cd; p_conf = cf; p_canc = cn;
  endtask

  task automatic cmp_obs(input string nm, input obs_t e);
    obs_t a;
    a = {state, vote_en, vote_sel, votes_cast,
         timeout_evt, invalid_evt, results_valid};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got st=%0d ven=%0b sel=%0d votes=%0d tmo=%0b inv=%0b rv=%0b, want st=%0d ven=%0b sel=%0d votes=%0d tmo=%0b inv=%0b rv=%0b",
               nm, $time, a.st, a.ven, a.sel, a.votes, a.tmo, a.inv, a.rv,
               e.st, e.ven, e.sel, e.votes, e.tmo, e.inv, e.rv);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit o, input bit c, input bit a,
                       input logic [3:0] cd, input bit cf, input bit cn);
    @(negedge clk);
    rst_n = 1'b1;
    admin_open = o; admin_close = c; voter_auth = a;
    cand_btn = cd; confirm_btn = cf; cancel_btn = cn;
    model_step(o, c, a, cd, cf, cn);
    expq.push_back(model_obs());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 4'd0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 cmp_obs("reset_immediate", model_obs());
    repeat (n) begin
      @(negedge clk);
      expq.push_back(model_obs());
    end
  endtask

  // Monitor: one expected snapshot per clock, one queued vote per strobe
  initial begin : monitor
    obs_t e;
    int   s;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp_obs("cycle", e);
      end
      if (vote_en === 1'b1) begin
        n_cmp++;
        if (voteq.size() == 0) begin
          n_bad++;
          $display("FAIL vote_unexpected t=%0t: got sel=%0d, want no vote",
                   $time, vote_sel);
        end else begin
          s = voteq.pop_front();
          if (vote_sel !== 2'(s)) begin
            n_bad++;
            $display("FAIL vote_sel t=%0t: got %0d, want %0d",
                     $time, vote_sel, s);
          end
        end
      end
    end
  end

  initial begin : stim
    int r, budget;
    bit o, c, a, cf, cn;
    logic [3:0] cd;
    rst_n = 1'b0;
    model_reset();
    do_reset(2);

    // Single vote for candidate 2, then cooldown back to IDLE
    drive(1, 0, 0, 4'd0, 0, 0); idle(1);
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b0100, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 0);
    idle(6);
    chk("vote1_count", votes_cast, 1);
    chk("vote1_sel", vote_sel, 2);
    chk("after_cooldown_idle", state, 1);

    // Illegal press, reselect, cancel, vote candidate 0
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b0011, 0, 0); idle(1);
    chk("invalid_stays_armed", state, 2);
    drive(0, 0, 0, 4'b1000, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 0, 1); idle(1);
    drive(0, 0, 0, 4'b0001, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 0);
    idle(6);
    chk("vote2_sel", vote_sel, 0);
    chk("vote2_count", votes_cast, 2);

    // Timeout on the 8th edge after auth
    drive(0, 0, 1, 4'd0, 0, 0);
    idle(9);
    chk("timeout_pulse", timeout_evt, 1);
    chk("timeout_idle", state, 1);
    chk("timeout_votes", votes_cast, 2);

    // Same-edge confirm+cancel, then confirm+close
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b0010, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 1); idle(1);
    chk("conf_cancel_armed", state, 2);
    drive(0, 0, 0, 4'b0001, 0, 0); idle(1);
    drive(0, 1, 0, 4'd0, 1, 0); idle(2);
    chk("conf_close_final", state, 6);
    chk("conf_close_votes", votes_cast, 2);

    // Close during cooldown defers FINAL; later presses do nothing
    do_reset(2);
    drive(1, 0, 0, 4'd0, 0, 0); idle(1);
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b1000, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 0); idle(2);
    drive(0, 1, 0, 4'd0, 0, 0); idle(1);
    chk("close_deferred", state, 5);
    idle(3);
    chk("final_after_cool", state, 6);
    chk("results_valid", results_valid, 1);
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b0001, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 0); idle(3);

    // Open held through reset release acts on the first edge
    admin_open = 1'b1;
    do_reset(2);
    drive(1, 0, 0, 4'd0, 0, 0); idle(1);
    chk("held_open_edge", state, 1);

    // Reset while CAST is showing
    drive(0, 0, 1, 4'd0, 0, 0); idle(1);
    drive(0, 0, 0, 4'b0010, 0, 0); idle(1);
    drive(0, 0, 0, 4'd0, 1, 0);
    do_reset(1);
    idle(8);
    chk("cast_reset_closed", state, 0);
    chk("cast_reset_votes", votes_cast, 0);

    // Random presses against the reference model
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset($urandom_range(1, 2));
      end else begin
        o  = ($urandom_range(0, 19) == 0);
        c  = ($urandom_range(0, 599) == 0);
        a  = ($urandom_range(0, 5) == 0);
        cd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                         : 4'd0;
        cf = ($urandom_range(0, 5) == 0);
        cn = ($urandom_range(0, 11) == 0);
        drive(o, c, a, cd, cf, cn);
      end
    end

    idle(2);
    budget = 20;
    while (expq.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("scoreboard_drained", expq.size(), 0);
    chk("votes_all_seen", voteq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voting_session_ctrl.md
VOTING_SESSION_CTRL -- requirements
Module: voting_session_ctrl

Interface
REQ-001 The block SHALL have the parameter CTR_WIDTH, default 16, giving the width of votes_cast.
REQ-002 The block SHALL have the parameter TIMEOUT_CYCLES, default 1000, giving the booth inactivity limit in cycles (minimum 2).
REQ-003 The block SHALL have the parameter COOLDOWN_CYCLES, default 4, giving the post-vote lockout in cycles (minimum 1).
REQ-004 The block SHALL use one clock, clk (input, 1 bit), with all logic on its rising edge.
REQ-005 The block SHALL use rst_n (input, 1 bit) as its reset, which is asynchronous and active-low.
REQ-006 admin_open (input, 1 bit) SHALL be the officer's button that opens the election.
REQ-007 admin_close (input, 1 bit) SHALL be the officer's button that closes the election.
REQ-008 voter_auth (input, 1 bit) SHALL be the button that unlocks the booth for one voter.
REQ-009 cand_btn (input, 4 bits) SHALL be the candidate buttons, with bit i selecting candidate i.
REQ-010 confirm_btn (input, 1 bit) SHALL confirm the pending selection.
REQ-011 cancel_btn (input, 1 bit) SHALL discard the pending selection.
REQ-012 vote_en (output, 1 bit) SHALL be a one-cycle vote strobe to the tally datapath.
REQ-013 vote_sel (output, 2 bits) SHALL give the candidate index, valid while vote_en is high.
REQ-014 state (output, 3 bits) SHALL give the current FSM state code.
REQ-015 votes_cast (output, CTR_WIDTH bits) SHALL give the total number of accepted votes.
REQ-016 timeout_evt (output, 1 bit) SHALL pulse for one cycle when a booth session times out.
REQ-017 invalid_evt (output, 1 bit) SHALL pulse for one cycle when an illegal candidate press occurs.
REQ-018 results_valid (output, 1 bit) SHALL be high once the election is final.

Function
REQ-019 Every button input SHALL be rising-edge detected against a per-input previous-value register, so that edge = input AND NOT previous, evaluated at the current clock edge.
REQ-020 State codes SHALL be: CLOSED=0, IDLE=1, ARMED=2, CONFIRM=3, CAST=4, COOLDOWN=5, FINAL=6.
REQ-021 In CLOSED, an admin_open edge SHALL move the FSM to IDLE, and all other inputs SHALL be ignored.
REQ-022 In IDLE, a voter_auth edge SHALL move the FSM to ARMED and load the timer.
REQ-023 In ARMED, a cand_btn edge pattern with exactly one bit set SHALL latch that index, move the FSM to CONFIRM, and reload the timer.
REQ-024 A cand_btn edge pattern with two or more bits set SHALL pulse invalid_evt, latch nothing, and leave the state unchanged.
REQ-025 In CONFIRM, a single-bit cand_btn edge SHALL relatch the index and reload the timer, with the FSM staying in CONFIRM.
REQ-026 In CONFIRM, a cancel edge SHALL move the FSM to ARMED and reload the timer.
REQ-027 In CONFIRM, a confirm edge SHALL move the FSM to CAST.
REQ-028 A confirm edge in ARMED SHALL be ignored.
REQ-029 Event priority in ARMED and CONFIRM SHALL be, from highest to lowest: admin_close, timeout, cancel, confirm, cand_btn.
REQ-030 A confirm edge at clock edge N SHALL produce CAST and vote_en=1 in cycle N+1, exactly one cycle, with vote_sel equal to the latched index.
REQ-031 vote_en SHALL be 0 in every state other than CAST, and vote_sel SHALL hold the latched index at all times.
REQ-032 On leaving CAST, votes_cast SHALL increment, saturating at all-ones, and the FSM SHALL enter COOLDOWN.
REQ-033 COOLDOWN SHALL last COOLDOWN_CYCLES cycles and then return to IDLE, with all voter inputs ignored during it.
REQ-034 The timer SHALL expire on the TIMEOUT_CYCLES-th clock edge after its last load while in ARMED or CONFIRM.
REQ-035 On timer expiry, timeout_evt SHALL pulse, the FSM SHALL return to IDLE, and no vote SHALL be issued.
REQ-036 An admin_close edge in IDLE, ARMED or CONFIRM SHALL move the FSM to FINAL immediately, discarding any pending selection.
REQ-037 An admin_close edge in CAST or COOLDOWN SHALL be latched and SHALL take effect at the end of COOLDOWN, with FINAL entered instead of IDLE.
REQ-038 In FINAL, results_valid SHALL be 1 and the FSM SHALL ignore all inputs until reset.
REQ-039 An admin_close edge in CLOSED SHALL be ignored.
REQ-040 A button held high does not repeat; a new press SHALL require a low cycle before the next edge is recognised.

Reset
REQ-041 Asserting rst_n low SHALL immediately force state=CLOSED and clear vote_en, vote_sel, votes_cast, timeout_evt, invalid_evt, results_valid, the timer, the latched close request and all previous-value registers to 0.
REQ-042 Reset asserted mid-session, including during CAST, SHALL abandon the session with no vote issued after reset.
REQ-043 A button held high through reset release SHALL register as an edge on the first active clock edge.

Verification
REQ-044 The bench SHALL apply reset, then open, auth, cand_btn=0100, confirm, and check: vote_en high exactly one cycle, vote_sel=2, votes_cast=1, then COOLDOWN for 4 cycles, then IDLE.
REQ-045 The bench SHALL apply auth, cand_btn=0011, and check: invalid_evt pulses once, state stays ARMED; then cand_btn=1000, cancel, cand_btn=0001, confirm, and check vote_sel=0.
REQ-046 The bench SHALL apply auth with TIMEOUT_CYCLES=8 and no further input, and check: timeout_evt pulses on the 8th edge after auth, state=IDLE, votes_cast unchanged.
REQ-047 The bench SHALL drive confirm and cancel on the same edge in CONFIRM and check that the FSM enters ARMED with no vote; it SHALL also drive confirm and admin_close on the same edge and check that the FSM enters FINAL with no vote.
REQ-048 The bench SHALL apply admin_close during COOLDOWN and check: FINAL entered after the cooldown completes, results_valid=1, and later auth and confirm presses produce no vote_en.
REQ-049 The bench SHALL apply reset during CAST and check: all outputs 0, state=CLOSED, and no vote_en after reset release.
